// File: rtl/decode_pkg.sv
// Shared decode definitions: field widths, instruction classes, opcode ranges.
package decode_pkg;

    localparam int unsigned OP_W = 6;

    typedef enum logic [2:0] {
        CLS_NONE = 3'd0,
        CLS_R    = 3'd1,
        CLS_I    = 3'd2,
        CLS_B    = 3'd3,
        CLS_M    = 3'd4,
        CLS_ILL  = 3'd5
    } cls_e;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    localparam logic [OP_W-1:0] R_LO = 6'd1;
    localparam logic [OP_W-1:0] R_HI = 6'd15;
    localparam logic [OP_W-1:0] I_LO = 6'd16;
    localparam logic [OP_W-1:0] I_HI = 6'd23;
    localparam logic [OP_W-1:0] B_LO = 6'd24;
    localparam logic [OP_W-1:0] B_HI = 6'd27;
    localparam logic [OP_W-1:0] M_LO = 6'd28;
    localparam logic [OP_W-1:0] M_HI = 6'd47;

    // Map an opcode to its class; anything outside the defined ranges is illegal.
    function automatic cls_e classify(input logic [OP_W-1:0] op);
        if (op >= R_LO && op <= R_HI) return CLS_R;
        if (op >= I_LO && op <= I_HI) return CLS_I;
        if (op >= B_LO && op <= B_HI) return CLS_B;
        if (op >= M_LO && op <= M_HI) return CLS_M;
        return CLS_ILL;
    endfunction

endpackage

// File: rtl/decode_comb.sv
// Combinational instruction decode into a packed record.
module decode_comb
    import decode_pkg::*;
#(
    parameter int unsigned INSTR_W  = 32,
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned IMM_W    = 16,
    parameter int unsigned DATA_W   = 32,
    parameter bit          SIGN_EXT = 1'b1,
    localparam int unsigned REC_W   = 3 + OP_W + 4 * REG_AW + 3 + DATA_W
) (
    input  logic [INSTR_W-1:0] code_i,
    output logic [REC_W-1:0]   rec_o
);

    typedef struct packed {
        cls_e              cls;
        logic [OP_W-1:0]   op;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] shamt;
        logic              rd_en;
        logic              rs1_en;
        logic              rs2_en;
        logic [DATA_W-1:0] imm;
    } dec_t;

    localparam int unsigned FA_HI = INSTR_W - OP_W - 1;

    logic [OP_W-1:0]   op;
    logic [REG_AW-1:0] f_a, f_b, f_c, f_s;
    logic [IMM_W-1:0]  imm_raw;
    logic [DATA_W-1:0] imm_ext;
    dec_t              dec;

    assign op      = code_i[INSTR_W-1 -: OP_W];
    assign f_a     = code_i[FA_HI -: REG_AW];
    assign f_b     = code_i[FA_HI - REG_AW -: REG_AW];
    assign f_c     = code_i[FA_HI - 2 * REG_AW -: REG_AW];
    assign f_s     = code_i[FA_HI - 3 * REG_AW -: REG_AW];
    assign imm_raw = code_i[IMM_W-1:0];

    // Sign- or zero-extend the raw immediate to the data width.
    always_comb begin
        imm_ext = {DATA_W{SIGN_EXT & imm_raw[IMM_W-1]}};
        imm_ext[IMM_W-1:0] = imm_raw;
    end

    // Class-dependent field routing; unused fields stay at zero.
    always_comb begin
        dec     = '0;
        dec.cls = classify(op);
        dec.op  = op;
        case (dec.cls)
            CLS_R: begin
                dec.rd     = f_a;
                dec.rs1    = f_b;
                dec.rs2    = f_c;
                dec.shamt  = f_s;
                dec.rd_en  = 1'b1;
                dec.rs1_en = 1'b1;
                dec.rs2_en = 1'b1;
            end
            CLS_I: begin
                dec.rd     = f_a;
                dec.rs1    = f_b;
                dec.imm    = imm_ext;
                dec.rd_en  = 1'b1;
                dec.rs1_en = 1'b1;
            end
            CLS_B: begin
                dec.rs1    = f_a;
                dec.rs2    = f_b;
                dec.rd     = f_a;
                dec.imm    = imm_ext;
                dec.rd_en  = 1'b1;
                dec.rs1_en = 1'b1;
                dec.rs2_en = 1'b1;
            end
            CLS_M: begin
                dec.rs1    = f_a;
                dec.rs2    = f_b;
                dec.imm    = imm_ext;
                dec.rs1_en = 1'b1;
                dec.rs2_en = 1'b1;
            end
            default: begin
                dec.cls = CLS_ILL;
            end
        endcase
    end

    assign rec_o = dec;

endmodule

// File: rtl/decode_stage.sv
// Decode stage: combinational decode feeding a 2-entry skid FIFO, plus an illegal-instruction counter.
module decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned INSTR_W  = 32,
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned IMM_W    = 16,
    parameter int unsigned DATA_W   = 32,
    parameter bit          SIGN_EXT = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_code,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2:0]         out_class,
    output logic [5:0]         out_op,
    output logic [REG_AW-1:0]  out_rd,
    output logic [REG_AW-1:0]  out_rs1,
    output logic [REG_AW-1:0]  out_rs2,
    output logic               out_rd_en,
    output logic               out_rs1_en,
    output logic               out_rs2_en,
    output logic [REG_AW-1:0]  out_shamt,
    output logic [DATA_W-1:0]  out_imm,
    output logic [15:0]        ill_cnt
);

    localparam int unsigned REC_W = 3 + OP_W + 4 * REG_AW + 3 + DATA_W;

    typedef struct packed {
        cls_e              cls;
        logic [OP_W-1:0]   op;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] shamt;
        logic              rd_en;
        logic              rs1_en;
        logic              rs2_en;
        logic [DATA_W-1:0] imm;
    } dec_t;

    logic [REC_W-1:0] rec;
    dec_t             dec;
    occ_e             state_q, state_d;
    dec_t             ent0_q, ent0_d, ent1_q, ent1_d;
    logic             in_ready_q, out_valid_q;
    logic [15:0]      ill_cnt_q, ill_cnt_d;
    logic             in_xfer, out_xfer;

    decode_comb #(
        .INSTR_W  (INSTR_W),
        .REG_AW   (REG_AW),
        .IMM_W    (IMM_W),
        .DATA_W   (DATA_W),
        .SIGN_EXT (SIGN_EXT)
    ) u_decode_comb (
        .code_i (in_code),
        .rec_o  (rec)
    );

    assign dec = rec;

    // Occupancy next-state, entry movement and illegal counter update.
    always_comb begin
        state_d   = state_q;
        ent0_d    = ent0_q;
        ent1_d    = ent1_q;
        ill_cnt_d = ill_cnt_q;
        in_xfer   = in_valid && in_ready_q && !flush;
        out_xfer  = out_valid_q && out_ready;

        if (in_xfer && dec.cls == CLS_ILL && ill_cnt_q != 16'hFFFF) begin
            ill_cnt_d = ill_cnt_q + 16'd1;
        end

        if (flush) begin
            state_d = OCC_EMPTY;
            ent0_d  = '0;
            ent1_d  = '0;
        end else begin
            case (state_q)
                OCC_EMPTY: begin
                    if (in_xfer) begin
                        ent0_d  = dec;
                        state_d = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (in_xfer && out_xfer) begin
                        ent0_d = dec;
                    end else if (in_xfer) begin
                        ent1_d  = dec;
                        state_d = OCC_FULL;
                    end else if (out_xfer) begin
                        ent0_d  = '0;
                        state_d = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (out_xfer) begin
                        ent0_d  = ent1_q;
                        ent1_d  = '0;
                        state_d = OCC_ONE;
                    end
                end
                default: begin
                    state_d = OCC_EMPTY;
                    ent0_d  = '0;
                    ent1_d  = '0;
                end
            endcase
        end
    end

    // State, entries, handshake flags and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= OCC_EMPTY;
            ent0_q      <= '0;
            ent1_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            ill_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            ent0_q      <= ent0_d;
            ent1_q      <= ent1_d;
            in_ready_q  <= (state_d != OCC_FULL);
            out_valid_q <= (state_d != OCC_EMPTY);
            ill_cnt_q   <= ill_cnt_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_class  = ent0_q.cls;
    assign out_op     = ent0_q.op;
    assign out_rd     = ent0_q.rd;
    assign out_rs1    = ent0_q.rs1;
    assign out_rs2    = ent0_q.rs2;
    assign out_rd_en  = ent0_q.rd_en;
    assign out_rs1_en = ent0_q.rs1_en;
    assign out_rs2_en = ent0_q.rs2_en;
    assign out_shamt  = ent0_q.shamt;
    assign out_imm    = ent0_q.imm;
    assign ill_cnt    = ill_cnt_q;

endmodule
